// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter and, later, a matching receiver.
//   PAR_NONE / PAR_EVEN / PAR_ODD : encodings of the 2-bit parity-mode input
//                                   (2'b11 also means no parity)
//   uart_tx_state_t               : transmitter FSM state encoding
//   UART_DIV_MIN                  : smallest usable bit period in clocks
//   parity_en()                   : 1 when a parity mode inserts a parity bit
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int UART_DIV_MIN = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } uart_tx_state_t;

    function automatic logic parity_en(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous show-ahead FIFO. o_data always presents the oldest entry, so a
// consumer can capture it in the same cycle it asserts i_pop.
// Ports:
//   clk, rst          clock, synchronous active-high reset (empties the FIFO)
//   i_push, i_data    write request and data; ignored while full
//   o_full            no free entry
//   i_pop, o_data     read request and head-of-queue data; ignored while empty
//   o_empty           no stored entry
//   o_level           number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    output logic                     o_full,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_level   = r_wr_ptr - r_rd_ptr;
    assign o_full    = (o_level == (AW+1)'(DEPTH));
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// -----------------------------------------------------------------------------
// uart_tx_cfg
// Buffered UART transmitter with runtime divisor, parity and stop-bit count.
// Frames are sent LSB-first; queued frames follow each other with no idle gap.
// Ports:
//   clk, rst          clock, synchronous active-high reset (aborts frame,
//                     discards queued bytes)
//   data_i, valid_i   byte push; accepted when valid_i && ready_o
//   ready_o           FIFO not full
//   div_i             clocks per bit (0 and 1 behave as 2), latched per frame
//   par_i             00 none, 01 even, 10 odd, 11 none; latched per frame
//   stop2_i           two stop bits when 1; latched per frame
//   level_o           FIFO occupancy
//   busy_o            frame in progress or bytes queued
//   tx_o              serial line, idle high, registered
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | line high, waiting for a queued byte
// START  | start bit (low)
// DATA   | data bits, shift-register bit 0 on the line
// PARITY | parity bit (skipped when parity is off)
// STOP1  | first stop bit (high)
// STOP2  | second stop bit (high), only when two stop bits latched
// -----------------------------------------------------------------------------
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [DIV_W-1:0]              div_i,
    input  logic [1:0]                    par_i,
    input  logic                          stop2_i,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          busy_o,
    output logic                          tx_o
);

    localparam int BW = $clog2(DATA_BITS);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(UART_DIV_MIN);
    localparam logic [BW-1:0]    BIT_LAST = BW'(DATA_BITS - 1);

    logic                   w_full;
    logic                   w_empty;
    logic                   w_pop;
    logic                   w_tick;
    logic                   w_frame_end;
    logic                   w_par_bit;
    logic [DIV_W-1:0]       w_div_eff;
    logic [DATA_BITS-1:0]   w_head;

    uart_tx_state_t         r_state;
    logic [DIV_W-1:0]       r_cnt;
    logic [DIV_W-1:0]       r_div;
    logic [DATA_BITS-1:0]   r_shift;
    logic [BW-1:0]          r_bit;
    logic                   r_par_en;
    logic                   r_par_bit;
    logic                   r_stop2;
    logic                   r_tx;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (valid_i),
        .i_data  (data_i),
        .o_full  (w_full),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_level (level_o)
    );

    assign w_tick      = (r_cnt == r_div - DIV_ONE);
    assign w_frame_end = w_tick && ((r_state == STOP2) || ((r_state == STOP1) && !r_stop2));
    // Popping on the last stop cycle lets the next start bit follow directly.
    assign w_pop       = !w_empty && ((r_state == IDLE) || w_frame_end);
    assign w_div_eff   = (div_i < DIV_MIN) ? DIV_MIN : div_i;
    assign w_par_bit   = (^w_head) ^ (par_i == PAR_ODD);

    assign ready_o = !w_full;
    assign busy_o  = (r_state != IDLE) || !w_empty;
    assign tx_o    = r_tx;

    // r_tx is loaded with the level of the state being entered, so the line
    // changes on the same edge as the state and never glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_div     <= DIV_MIN;
            r_shift   <= '0;
            r_bit     <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_stop2   <= 1'b0;
            r_tx      <= 1'b1;
        end else if (w_pop) begin
            r_state   <= START;
            r_cnt     <= '0;
            r_div     <= w_div_eff;
            r_shift   <= w_head;
            r_bit     <= '0;
            r_par_en  <= parity_en(par_i);
            r_par_bit <= w_par_bit;
            r_stop2   <= stop2_i;
            r_tx      <= 1'b0;
        end else if (r_state != IDLE) begin
            if (!w_tick) begin
                r_cnt <= r_cnt + DIV_ONE;
            end else begin
                r_cnt <= '0;
                case (r_state)
                    START: begin
                        r_state <= DATA;
                        r_tx    <= r_shift[0];
                    end
                    DATA: begin
                        if (r_bit == BIT_LAST) begin
                            if (r_par_en) begin
                                r_state <= PARITY;
                                r_tx    <= r_par_bit;
                            end else begin
                                r_state <= STOP1;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_bit   <= r_bit + BW'(1);
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                        end
                    end
                    PARITY: begin
                        r_state <= STOP1;
                        r_tx    <= 1'b1;
                    end
                    STOP1: begin
                        r_state <= r_stop2 ? STOP2 : IDLE;
                        r_tx    <= 1'b1;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
module tb_uart_tx_cfg;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data_i;
    logic        valid_i;
    logic        ready_o;
    logic [15:0] div_i;
    logic [1:0]  par_i;
    logic        stop2_i;
    logic [2:0]  level_o;
    logic        busy_o;
    logic        tx_o;

    int n_run  = 0;
    int n_fail = 0;

    uart_tx_cfg #(
        .DATA_BITS  (8),
        .DIV_W      (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .div_i   (div_i),
        .par_i   (par_i),
        .stop2_i (stop2_i),
        .level_o (level_o),
        .busy_o  (busy_o),
        .tx_o    (tx_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; leaves the byte offered for exactly one cycle.
    task automatic push(input logic [7:0] d);
        data_i  = d;
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    // Called at the negedge of the first start-bit cycle. Checks line level
    // and busy for every clock of the frame; returns at the negedge of the
    // first cycle after the frame.
    task automatic check_frame(input logic [7:0] d, input int dv, input logic [1:0] pm,
                               input logic s2, input string tag);
        logic [11:0] bits;
        int n;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = d[i];
        n = 9;
        if (pm == 2'b01 || pm == 2'b10) begin
            bits[n] = (^d) ^ (pm == 2'b10);
            n++;
        end
        bits[n] = 1'b1;
        n++;
        if (s2) begin
            bits[n] = 1'b1;
            n++;
        end
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < dv; c++) begin
                check($sformatf("%s_bit%0d_clk%0d", tag, b, c), {30'd0, busy_o, tx_o}, {30'd0, 1'b1, bits[b]});
                @(negedge clk);
            end
        end
    endtask

    initial begin
        bit saw_low;
        rst     = 1'b1;
        valid_i = 1'b0;
        data_i  = 8'h00;
        div_i   = 16'd4;
        par_i   = 2'b00;
        stop2_i = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tx",    tx_o,    1);
        check("rst_busy",  busy_o,  0);
        check("rst_ready", ready_o, 1);
        check("rst_level", level_o, 0);
        rst = 1'b0;
        @(negedge clk);

        // 8N1, div 4, 0xA5: start two cycles after the push, 40-clock frame
        push(8'hA5);
        check("push_level1", level_o, 1);
        check("push_busy1",  busy_o,  1);
        check("push_tx_idle", tx_o,   1);
        @(negedge clk);
        check("latency_start", tx_o, 0);
        check_frame(8'hA5, 4, 2'b00, 1'b0, "8n1");
        check("8n1_end_busy", busy_o, 0);
        check("8n1_end_tx",   tx_o,   1);

        // Even then odd parity, div 3, 33-clock frames
        div_i = 16'd3;
        par_i = 2'b01;
        push(8'hA5);
        @(negedge clk);
        check_frame(8'hA5, 3, 2'b01, 1'b0, "even");
        check("even_end_busy", busy_o, 0);
        par_i = 2'b10;
        push(8'hA5);
        @(negedge clk);
        check_frame(8'hA5, 3, 2'b10, 1'b0, "odd");
        check("odd_end_busy", busy_o, 0);

        // Two stop bits, div 2, second byte follows with no gap
        par_i   = 2'b00;
        div_i   = 16'd2;
        stop2_i = 1'b1;
        data_i  = 8'h00;
        valid_i = 1'b1;
        @(negedge clk);
        data_i  = 8'h3C;
        @(negedge clk);
        valid_i = 1'b0;
        check("pushpop_level", level_o, 1);
        check_frame(8'h00, 2, 2'b00, 1'b1, "stop2a");
        check_frame(8'h3C, 2, 2'b00, 1'b1, "stop2b");
        check("stop2_end_busy", busy_o, 0);
        stop2_i = 1'b0;

        // FIFO full: five pushes during a frame, fifth dropped
        push(8'h11);
        @(negedge clk);
        fork
            check_frame(8'h11, 2, 2'b00, 1'b0, "full0");
            begin
                data_i  = 8'h22;
                valid_i = 1'b1;
                @(negedge clk);
                data_i  = 8'h33;
                @(negedge clk);
                data_i  = 8'h44;
                @(negedge clk);
                data_i  = 8'h55;
                @(negedge clk);
                data_i  = 8'h66;
                check("full_ready", ready_o, 0);
                check("full_level", level_o, 4);
                @(negedge clk);
                valid_i = 1'b0;
                check("full_level_drop", level_o, 4);
            end
        join
        check_frame(8'h22, 2, 2'b00, 1'b0, "full1");
        check_frame(8'h33, 2, 2'b00, 1'b0, "full2");
        check_frame(8'h44, 2, 2'b00, 1'b0, "full3");
        check_frame(8'h55, 2, 2'b00, 1'b0, "full4");
        check("full_end_busy",  busy_o,  0);
        check("full_end_level", level_o, 0);
        check("full_end_tx",    tx_o,    1);

        // Divisor change mid-frame only affects the next frame; div 0 -> 2
        div_i   = 16'd4;
        data_i  = 8'h5A;
        valid_i = 1'b1;
        @(negedge clk);
        data_i  = 8'hC3;
        @(negedge clk);
        valid_i = 1'b0;
        fork
            check_frame(8'h5A, 4, 2'b00, 1'b0, "div4");
            begin
                repeat (6) @(negedge clk);
                div_i = 16'd8;
            end
        join
        check_frame(8'hC3, 8, 2'b00, 1'b0, "div8");
        check("div8_end_busy", busy_o, 0);
        div_i = 16'd0;
        push(8'h0F);
        @(negedge clk);
        check_frame(8'h0F, 2, 2'b00, 1'b0, "div0");
        check("div0_end_busy", busy_o, 0);

        // Reset during DATA with two bytes queued
        div_i   = 16'd4;
        data_i  = 8'hAA;
        valid_i = 1'b1;
        @(negedge clk);
        data_i  = 8'hBB;
        @(negedge clk);
        data_i  = 8'hCC;
        @(negedge clk);
        valid_i = 1'b0;
        check("mid_level", level_o, 2);
        repeat (6) @(negedge clk);
        check("mid_busy", busy_o, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_tx",    tx_o,    1);
        check("midrst_level", level_o, 0);
        check("midrst_busy",  busy_o,  0);
        check("midrst_ready", ready_o, 1);
        rst = 1'b0;
        saw_low = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx_o !== 1'b1 || busy_o !== 1'b0) saw_low = 1'b1;
        end
        check("post_rst_quiet", saw_low, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised UART transmitter. It buffers bytes in a small FIFO and serialises them LSB-first onto `tx_o`. Baud divisor, parity mode and stop-bit count are runtime inputs. It replaces the fixed 9600-baud, 8N1, unbuffered transmitter on the SoC peripheral bus. Consecutive frames go out back-to-back with no idle gap while the FIFO holds data.

## Interface
Parameters:
- `DATA_BITS`, default 8: data bits per frame, 5..8.
- `DIV_W`, default 16: width of the baud divisor.
- `FIFO_DEPTH`, default 4: FIFO entries; power of two, at least 2.

Ports:
- `clk`  in  1: the single clock. Everything is synchronous to its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `data_i`  in  DATA_BITS: byte to enqueue.
- `valid_i`  in  1: push request. A push is accepted when `valid_i` and `ready_o` are both high.
- `ready_o`  out  1: FIFO not full.
- `div_i`  in  DIV_W: bit period in clocks. Values 0 and 1 are treated as 2.
- `par_i`  in  2: parity mode. 00 none, 01 even, 10 odd, 11 none.
- `stop2_i`  in  1: 1 selects two stop bits, 0 selects one.
- `level_o`  out  $clog2(FIFO_DEPTH)+1: FIFO occupancy.
- `busy_o`  out  1: high when a frame is in progress or the FIFO is non-empty.
- `tx_o`  out  1: serial line. Idle level is high.

## Operation
- The FSM states are IDLE, START, DATA, PARITY, STOP1 and STOP2.
- **Loading a frame.** From IDLE with the FIFO non-empty, the FSM pops one entry and moves to START. At the pop it latches the data into a shift register and latches `div_i`, `par_i` and `stop2_i`.
  - Configuration changes take effect only at the next pop.
- **Line level per state:**
  - IDLE: 1.
  - START: 0.
  - DATA: shift-register bit 0. The register shifts right once per bit period; DATA lasts exactly DATA_BITS periods.
  - PARITY: XOR of the data bits for even mode; its inverse for odd mode. The state is skipped when parity is none.
  - STOP1 and STOP2: 1. STOP2 is skipped unless stop2 was latched.
- **Bit period.** A baud counter counts 0..div-1, where div is the latched value. The state advances when the counter reaches div-1, and the counter restarts at 0 on every state change.
- **End of frame.** On the last cycle of the final stop state:
  - If the FIFO is non-empty, the FSM pops and goes directly to START.
  - Otherwise it goes to IDLE.
- **FIFO.**
  - `ready_o` is the inverse of full and does not depend on a same-cycle pop.
  - A push and a pop in the same cycle leave `level_o` unchanged.
  - A push while full is ignored.
- **Frame length.** Exactly (1 + DATA_BITS + P + S) × div clocks, where P is 0 or 1 (parity) and S is 1 or 2 (stop bits).

## Timing
- **Reset values:** `tx_o`=1, `busy_o`=0, `ready_o`=1, `level_o`=0, FSM in IDLE, FIFO pointers 0, baud counter 0.
- **Reset during a frame:** the frame is aborted and FIFO contents are discarded. `tx_o` is high from the cycle after reset is sampled.
- **Push latency:** a push accepted in cycle k into an empty FIFO with the FSM in IDLE produces:
  - `level_o`=1 in cycle k+1;
  - the pop at the end of cycle k+1;
  - `tx_o` falling in cycle k+2.
- **Output registering:** `tx_o` is driven from registered state and shift-register bits only, so it is glitch-free.
- **`busy_o` timing:** rises the cycle after the first accepted push. Falls in the first IDLE cycle that also has an empty FIFO.

## Structure
- Package `uart_pkg` holds:
  - the parity-mode constants `PAR_NONE`, `PAR_EVEN`, `PAR_ODD`;
  - the FSM state typedef `uart_tx_state_t`;
  - the minimum divisor constant `UART_DIV_MIN` = 2.
- Sub-module `uart_tx_fifo` is a synchronous FIFO parametrised by width and depth. It has push/pop/full/empty/level ports and is reusable by a future receiver.
- The top level contains the FSM, baud counter, shift register and parity accumulator.

## Test plan
- **Basic 8N1 frame.** div=4, par=00, stop2=0; push 0xA5 → `tx_o` goes 0, then 1,0,1,0,0,1,0,1, then 1, each level held for 4 clocks. The first 0 appears 2 cycles after the push, and the frame lasts 40 clocks.
- **Parity.** div=3, push 0xA5 with even parity → parity bit 0; with odd parity → 1. Frame length 33 clocks.
- **Two stop bits.** div=2, stop2=1, push 0x00 → stop level held for 4 clocks. With a second byte queued, its start bit follows with no idle cycle.
- **FIFO full.** FIFO_DEPTH=4, five pushes in consecutive cycles while the first frame is loading → the fifth push is dropped. All four accepted bytes are transmitted in order with no gaps, then `busy_o` goes to 0.
- **Divisor handling.** Change `div_i` from 4 to 8 mid-frame → the current frame keeps 4 clocks per bit and the next frame uses 8. `div_i`=0 → 2 clocks per bit.
- **Reset mid-frame.** Assert `rst` during the DATA state with 2 bytes queued → next cycle `tx_o`=1, `level_o`=0, `busy_o`=0, and nothing is transmitted afterwards.
